// File: rtl/div_ctrl.sv
// Sequencing front-end for an iterative 32-bit unsigned divider core: RV32M DIV/DIVU/REM/REMU.
// Resolves divide-by-zero and signed overflow locally and sign-corrects core results.
module div_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             div_start,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  input  logic             div_finish
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        dividend_q, dividend_d;
  logic [31:0]        divisor_q, divisor_d;
  logic [31:0]        result_q, result_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;

  logic               is_signed;
  logic [31:0]        abs_a, abs_b;
  logic               b_zero, sgn_ovf;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  assign is_signed = ~in_op[0];
  assign abs_a     = (is_signed && in_a[31]) ? (~in_a + 32'd1) : in_a;
  assign abs_b     = (is_signed && in_b[31]) ? (~in_b + 32'd1) : in_b;
  assign b_zero    = (in_b == 32'd0);
  assign sgn_ovf   = is_signed && (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tag_d      = tag_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d       = in_op;
          tag_d      = in_tag;
          dividend_d = abs_a;
          divisor_d  = abs_b;
          neg_q_d    = is_signed & (in_a[31] ^ in_b[31]);
          neg_r_d    = is_signed & in_a[31];
          if (b_zero) begin
            result_d = in_op[1] ? in_a : 32'hFFFF_FFFF;
            state_d  = DONE;
          end else if (sgn_ovf) begin
            result_d = in_op[1] ? 32'd0 : 32'h8000_0000;
            state_d  = DONE;
          end else begin
            state_d  = START;
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // Finish is only trusted here: the core clears its stale level on the start edge.
        if (div_finish) begin
          if (op_q[1]) result_d = neg_r_q ? (~div_remainder + 32'd1) : div_remainder;
          else         result_d = neg_q_q ? (~div_quotient + 32'd1) : div_quotient;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      tag_q      <= '0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      result_q   <= 32'd0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign div_start    = (state_q == START);
  assign out_result   = result_q;
  assign out_tag      = tag_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule
